discus_snoop_arbiter: RTL and testbench
=======================================

Name: discus_snoop_arbiter

Overview:
- Shares the discus core's single snoop port (data-memory read/write, program-memory write) between two requesters: a host loader (h_) and a debug monitor (d_).
- Round-robin arbitration with bounded bursts; every accepted transaction becomes exactly one snoop cycle.
- Owns the core's reset line so the host can hold the CPU while it loads program memory.
- Runs on the same clock as the core's snoop_clk.

Parameters:
- BURST_MAX, 16: maximum consecutive accepts for one requester while the other is waiting (range 1..255).

Ports:
- clk  in  1  system clock; also drives the core's snoop_clk
- reset  in  1  synchronous, active-low reset
- h_valid  in  1  host request valid
- h_ready  out  1  host request accepted this cycle when h_valid is also high
- h_write  in  1  1=write, 0=read
- h_prog  in  1  1=program memory, 0=data memory
- h_addr  in  8  address
- h_data  in  8  write data
- h_hold  in  1  host requests the CPU be held in reset
- d_valid, d_ready, d_write, d_prog, d_addr, d_data  as h_*, for the debug requester
- rsp_valid  out  1  read response strobe, one cycle
- rsp_src  out  1  0=host, 1=debug; owner of this response
- rsp_data  out  8  read data
- snoopa  out  8  to core
- snoopd  out  8  to core
- snoopm  out  1  to core; data-memory write strobe
- snoopp  out  1  to core; program-memory write strobe
- snoopq  in  8  from core; registered read data
- cpu_reset  out  1  to core reset, active-high

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, last_grant=debug, burst count=0.
  - h_ready=d_ready=0, snoopm=snoopp=0, snoopa=snoopd=0.
  - rsp_valid=0, rsp_src=0, rsp_data=0, cpu_reset=1.
  - Any in-flight read is discarded; no response is ever issued for it.
- States:
  - IDLE: no grant.
    - Only one valid: go to that requester's grant state.
    - Both valid: grant the requester other than last_grant (after reset the host wins).
  - HOST / DBG: ready=1 for the granted requester only; ready is a pure decode of state.
    - Each accept increments cnt and sets last_grant.
    - Granted valid low at an edge: go to DBG/HOST if the other requester is valid, else IDLE.
    - cnt reaches BURST_MAX while the other requester is valid: switch to the other grant state and clear cnt.
    - If the other requester is not waiting, the burst continues and cnt saturates.
- Throughput: one transaction per clk while granted. Entering a grant from IDLE costs one bubble cycle.
- Snoop cycle: request accepted at edge E0; snoopa/snoopd/strobes are registered and present for exactly the cycle after E0.
  - Write, prog=0: snoopm=1.
  - Write, prog=1: snoopp=1.
  - Read: both strobes 0, snoopa=addr.
  - Strobes are never both 1 and never high for more than one cycle per accept.
- Read latency:
  - The core samples at E1.
  - rsp_data is registered from snoopq at E2; rsp_valid=1 for the cycle after E2, with rsp_src set to the owner.
  - Reads are fully pipelined, back-to-back, and responses stay in accept order. There is no response backpressure.
- A read with prog=1 (program memory is write-only) is accepted with no strobe and responds normally with rsp_data=8'h00.
- cpu_reset:
  - Set at any edge where h_hold==1.
  - Cleared at the first edge where h_hold==0, the arbiter is not in HOST, and snoopp==0.
  - This guarantees the last program write lands before the core runs.
- Simultaneous events:
  - The burst-limit switch takes priority over continuing the burst.
  - Both valid in IDLE resolves as above.
  - A reset asserted mid-burst drops the grant in the same edge.

Optional Feature:
- Macro: DISCUS_SNOOP_PROG_LOCK_EN.
- Defined: a program-memory write from the debug requester while cpu_reset==0 is accepted (d_ready handshake completes) but produces no strobe. A sticky output prog_lock_err (1 bit, reset 0) is set, and cleared only by reset.
- Not defined: prog_lock_err does not exist; program writes from either requester always strobe snoopp.

Test Plan:
- Host write to data memory, addr 8'h10, data 8'hA5 → snoopm=1 for one cycle with snoopa=10, snoopd=A5. A following debug read of 10 gives rsp_valid two cycles after accept, rsp_data=A5, rsp_src=1.
- Both valid continuously from reset, BURST_MAX=4 → host accepts exactly 4, then debug accepts 4, alternating; in IDLE with simultaneous valid the host is granted first.
- Host streams 8 reads of addrs 0..7 back-to-back → 8 consecutive rsp_valid cycles, in order, data equal to memory contents.
- h_hold=1, host writes 16 program bytes, then h_hold=0 in the same cycle as the last accept → cpu_reset drops only after the final snoopp pulse.
- Reset asserted one cycle after a read accept → no rsp_valid, all strobes 0, state IDLE, cpu_reset=1.
- With DISCUS_SNOOP_PROG_LOCK_EN: debug program write while cpu_reset=0 → no snoopp pulse and prog_lock_err=1; the same write while h_hold=1 → snoopp pulses.

Source files
------------

// File: rtl/discus_snoop_arbiter.sv
// ---------------------------------------------------------------------------
// discus_snoop_arbiter
//
// Shares the discus core's single snoop port between a host loader (h_*) and
// a debug monitor (d_*). Round-robin arbitration with bursts bounded by
// BURST_MAX while the other requester waits. Every accepted request becomes
// one registered snoop cycle. Reads return through a two-stage pipeline as a
// one-cycle rsp_valid strobe tagged with the owner. The block also owns the
// core reset (cpu_reset) so the host can hold the CPU while loading program
// memory.
//
// Ports:
//   clk, reset           clock (also the core's snoop_clk), sync active-low reset
//   h_valid/h_ready      host handshake; h_write/h_prog/h_addr/h_data request
//   h_hold               host asks for the CPU to be held in reset
//   d_*                  same request interface for the debug requester
//   rsp_valid/src/data   read response strobe, owner (0=host,1=debug), data
//   snoopa/snoopd        registered address / write data to the core
//   snoopm/snoopp        data-memory / program-memory write strobes
//   snoopq               registered read data from the core
//   cpu_reset            active-high core reset
//   prog_lock_err        (only with DISCUS_SNOOP_PROG_LOCK_EN) sticky error set
//                        by a debug program write while the CPU is running
//
// Configuration macro: DISCUS_SNOOP_PROG_LOCK_EN
// ---------------------------------------------------------------------------
module discus_snoop_arbiter #(
    parameter int unsigned BURST_MAX = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       h_valid,
    output logic       h_ready,
    input  logic       h_write,
    input  logic       h_prog,
    input  logic [7:0] h_addr,
    input  logic [7:0] h_data,
    input  logic       h_hold,
    input  logic       d_valid,
    output logic       d_ready,
    input  logic       d_write,
    input  logic       d_prog,
    input  logic [7:0] d_addr,
    input  logic [7:0] d_data,
    output logic       rsp_valid,
    output logic       rsp_src,
    output logic [7:0] rsp_data,
    output logic [7:0] snoopa,
    output logic [7:0] snoopd,
    output logic       snoopm,
    output logic       snoopp,
    input  logic [7:0] snoopq,
    output logic       cpu_reset
`ifdef DISCUS_SNOOP_PROG_LOCK_EN
    ,
    output logic       prog_lock_err
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOST = 2'd1,
        ST_DBG  = 2'd2
    } state_t;

    localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

    state_t     state_q, state_d;
    logic       last_dbg_q, last_dbg_d;     // 1 = debug was granted last
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cnt_inc;

    logic       h_acc, d_acc, acc;
    logic       sel_write, sel_prog;
    logic [7:0] sel_addr, sel_data;
    logic       lock_block;

    logic [7:0] snoopa_q, snoopa_d, snoopd_q, snoopd_d;
    logic       snoopm_q, snoopm_d, snoopp_q, snoopp_d;
    logic       rd1_q, rd1_d, rd1_src_q, rd1_src_d, rd1_prog_q, rd1_prog_d;
    logic       rd2_q, rd2_d, rd2_src_q, rd2_src_d, rd2_prog_q, rd2_prog_d;
    logic       rsp_valid_q, rsp_valid_d, rsp_src_q, rsp_src_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       cpu_reset_q, cpu_reset_d;
    logic       lock_err_q, lock_err_d;

    // Arbitration state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            last_dbg_q <= 1'b1;
            cnt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            last_dbg_q <= last_dbg_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state logic: round-robin grant with bounded bursts
    always_comb begin
        state_d    = state_q;
        last_dbg_d = last_dbg_q;
        cnt_d      = cnt_q;
        // Saturating increment: an unopposed burst simply keeps going.
        cnt_inc    = (cnt_q >= BURST_LIM) ? BURST_LIM : (cnt_q + 8'd1);
        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (h_valid && d_valid) begin
                    state_d = last_dbg_q ? ST_HOST : ST_DBG;
                end else if (h_valid) begin
                    state_d = ST_HOST;
                end else if (d_valid) begin
                    state_d = ST_DBG;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOST: begin
                if (h_valid) begin
                    last_dbg_d = 1'b0;
                    if ((cnt_inc == BURST_LIM) && d_valid) begin
                        state_d = ST_DBG;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    cnt_d   = 8'd0;
                    state_d = d_valid ? ST_DBG : ST_IDLE;
                end
            end
            ST_DBG: begin
                if (d_valid) begin
                    last_dbg_d = 1'b1;
                    if ((cnt_inc == BURST_LIM) && h_valid) begin
                        state_d = ST_HOST;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    cnt_d   = 8'd0;
                    state_d = h_valid ? ST_HOST : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Grant decode and selection of the accepted request
    always_comb begin
        h_ready   = (state_q == ST_HOST);
        d_ready   = (state_q == ST_DBG);
        h_acc     = h_ready & h_valid;
        d_acc     = d_ready & d_valid;
        acc       = h_acc | d_acc;
        sel_write = d_acc ? d_write : h_write;
        sel_prog  = d_acc ? d_prog  : h_prog;
        sel_addr  = d_acc ? d_addr  : h_addr;
        sel_data  = d_acc ? d_data  : h_data;
    end

    // Snoop cycle, read pipeline and cpu_reset next values
    always_comb begin
`ifdef DISCUS_SNOOP_PROG_LOCK_EN
        lock_block = d_acc & d_write & d_prog & ~cpu_reset_q;
`else
        lock_block = 1'b0;
`endif
        lock_err_d = lock_err_q | lock_block;
        snoopa_d   = acc ? sel_addr : 8'h00;
        snoopd_d   = acc ? sel_data : 8'h00;
        snoopm_d   = acc & sel_write & ~sel_prog;
        snoopp_d   = acc & sel_write & sel_prog & ~lock_block;
        // Stage 1: address on snoopa; stage 2: core's registered data on snoopq.
        rd1_d      = acc & ~sel_write;
        rd1_src_d  = d_acc;
        rd1_prog_d = sel_prog;
        rd2_d      = rd1_q;
        rd2_src_d  = rd1_src_q;
        rd2_prog_d = rd1_prog_q;
        rsp_valid_d = rd2_q;
        if (rd2_q) begin
            rsp_src_d  = rd2_src_q;
            // Program memory is write-only, so its reads return zero.
            rsp_data_d = rd2_prog_q ? 8'h00 : snoopq;
        end else begin
            rsp_src_d  = rsp_src_q;
            rsp_data_d = rsp_data_q;
        end
        // Release only once the host is off the port and the last program
        // write strobe has been presented to the core.
        if (h_hold) begin
            cpu_reset_d = 1'b1;
        end else if ((state_q != ST_HOST) && !snoopp_q) begin
            cpu_reset_d = 1'b0;
        end else begin
            cpu_reset_d = cpu_reset_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            snoopa_q    <= 8'h00;
            snoopd_q    <= 8'h00;
            snoopm_q    <= 1'b0;
            snoopp_q    <= 1'b0;
            rd1_q       <= 1'b0;
            rd1_src_q   <= 1'b0;
            rd1_prog_q  <= 1'b0;
            rd2_q       <= 1'b0;
            rd2_src_q   <= 1'b0;
            rd2_prog_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_src_q   <= 1'b0;
            rsp_data_q  <= 8'h00;
            cpu_reset_q <= 1'b1;
            lock_err_q  <= 1'b0;
        end else begin
            snoopa_q    <= snoopa_d;
            snoopd_q    <= snoopd_d;
            snoopm_q    <= snoopm_d;
            snoopp_q    <= snoopp_d;
            rd1_q       <= rd1_d;
            rd1_src_q   <= rd1_src_d;
            rd1_prog_q  <= rd1_prog_d;
            rd2_q       <= rd2_d;
            rd2_src_q   <= rd2_src_d;
            rd2_prog_q  <= rd2_prog_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_src_q   <= rsp_src_d;
            rsp_data_q  <= rsp_data_d;
            cpu_reset_q <= cpu_reset_d;
            lock_err_q  <= lock_err_d;
        end
    end

    assign snoopa    = snoopa_q;
    assign snoopd    = snoopd_q;
    assign snoopm    = snoopm_q;
    assign snoopp    = snoopp_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_src   = rsp_src_q;
    assign rsp_data  = rsp_data_q;
    assign cpu_reset = cpu_reset_q;
`ifdef DISCUS_SNOOP_PROG_LOCK_EN
    assign prog_lock_err = lock_err_q;
`endif

endmodule

// File: tb/tb_discus_snoop_arbiter.sv
// Testbench for discus_snoop_arbiter: scoreboard queues filled by the stimulus
// process, drained by a monitor on the falling clock edge. A small core model
// provides data/program memory behind the snoop port.
module tb_discus_snoop_arbiter;

    localparam int BM = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       h_valid, h_ready, h_write, h_prog, h_hold;
    logic [7:0] h_addr, h_data;
    logic       d_valid, d_ready, d_write, d_prog;
    logic [7:0] d_addr, d_data;
    logic       rsp_valid, rsp_src;
    logic [7:0] rsp_data, snoopa, snoopd, snoopq;
    logic       snoopm, snoopp, cpu_reset;
`ifdef DISCUS_SNOOP_PROG_LOCK_EN
    logic       prog_lock_err;
`endif

    always #5 clk = ~clk;

    discus_snoop_arbiter #(.BURST_MAX(BM)) dut (
        .clk(clk), .reset(reset),
        .h_valid(h_valid), .h_ready(h_ready), .h_write(h_write), .h_prog(h_prog),
        .h_addr(h_addr), .h_data(h_data), .h_hold(h_hold),
        .d_valid(d_valid), .d_ready(d_ready), .d_write(d_write), .d_prog(d_prog),
        .d_addr(d_addr), .d_data(d_data),
        .rsp_valid(rsp_valid), .rsp_src(rsp_src), .rsp_data(rsp_data),
        .snoopa(snoopa), .snoopd(snoopd), .snoopm(snoopm), .snoopp(snoopp),
        .snoopq(snoopq), .cpu_reset(cpu_reset)
`ifdef DISCUS_SNOOP_PROG_LOCK_EN
        , .prog_lock_err(prog_lock_err)
`endif
    );

    // Core model: registered read, data/program memory writes on strobes.
    logic [7:0] dmem [256];
    logic [7:0] pmem [256];
    logic       core_init = 1'b0;
    always @(posedge clk) begin
        if (!core_init) begin
            for (int i = 0; i < 256; i++) dmem[i] <= 8'(i) ^ 8'h5A;
            core_init <= 1'b1;
        end else begin
            if (snoopm) dmem[snoopa] <= snoopd;
        end
        if (snoopp) pmem[snoopa] <= snoopd;
        snoopq <= dmem[snoopa];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic src; logic [7:0] data; int cyc; } rsp_t;
    typedef struct { logic [7:0] a; logic [7:0] d; logic m; logic p; } snp_t;
    rsp_t rsp_q[$];
    snp_t snp_q[$];
    logic acc_log[$];
    logic [7:0] ref_mem [256];
    logic lock_on = 1'b0;
    int errors = 0;
    int checks = 0;
    rsp_t mon_r;
    snp_t mon_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event seen or missing, required otherwise", name);
    endtask

    // Monitor: compare every response / strobe against the scoreboards.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (rsp_q.size() == 0) fail_now("rsp_unexpected");
            else begin
                mon_r = rsp_q.pop_front();
                check("rsp_src", {31'd0, rsp_src}, {31'd0, mon_r.src});
                check("rsp_data", {24'd0, rsp_data}, {24'd0, mon_r.data});
                check("rsp_cycle", cyc, mon_r.cyc);
            end
        end
        if (snoopm || snoopp) begin
            check("strobe_excl", {31'd0, snoopm & snoopp}, 32'd0);
            if (snp_q.size() == 0) fail_now("snoop_unexpected");
            else begin
                mon_s = snp_q.pop_front();
                check("snoopa", {24'd0, snoopa}, {24'd0, mon_s.a});
                check("snoopd", {24'd0, snoopd}, {24'd0, mon_s.d});
                check("snoopm", {31'd0, snoopm}, {31'd0, mon_s.m});
                check("snoopp", {31'd0, snoopp}, {31'd0, mon_s.p});
            end
        end
    end

    task automatic expect_txn(input logic src, input logic w, input logic p,
                              input logic [7:0] a, input logic [7:0] d);
        snp_t s;
        rsp_t r;
        if (w) begin
            if (!(src && p && lock_on)) begin
                s.a = a; s.d = d; s.m = ~p; s.p = p;
                snp_q.push_back(s);
            end
            if (!p) ref_mem[a] = d;
        end else begin
            r.src = src;
            r.data = p ? 8'h00 : ref_mem[a];
            r.cyc = cyc + 3;
            rsp_q.push_back(r);
        end
    endtask

    // Drive one cycle at the falling edge; report which request gets accepted.
    task automatic step(input logic hv, input logic hw, input logic hp,
                        input logic [7:0] ha, input logic [7:0] hd,
                        input logic dv, input logic dw, input logic dp,
                        input logic [7:0] da, input logic [7:0] dd,
                        output logic h_acc, output logic d_acc);
        h_valid = hv; h_write = hw; h_prog = hp; h_addr = ha; h_data = hd;
        d_valid = dv; d_write = dw; d_prog = dp; d_addr = da; d_data = dd;
        h_acc = hv & h_ready;
        d_acc = dv & d_ready;
        if (h_acc) begin expect_txn(1'b0, hw, hp, ha, hd); acc_log.push_back(1'b0); end
        if (d_acc) begin expect_txn(1'b1, dw, dp, da, dd); acc_log.push_back(1'b1); end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic ha, da;
        repeat (n) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, ha, da);
    endtask

    task automatic host_txn(input logic w, input logic p, input logic [7:0] a, input logic [7:0] d);
        logic ha, da;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, w, p, a, d, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, ha, da);
            if (ha) return;
        end
        fail_now("host_timeout");
    endtask

    task automatic dbg_txn(input logic w, input logic p, input logic [7:0] a, input logic [7:0] d);
        logic ha, da;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, w, p, a, d, ha, da);
            if (da) return;
        end
        fail_now("dbg_timeout");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ha, da;
        int hi, di, i;
        reset = 1'b0; h_hold = 1'b0;
        h_valid = 1'b0; h_write = 1'b0; h_prog = 1'b0; h_addr = 8'h00; h_data = 8'h00;
        d_valid = 1'b0; d_write = 1'b0; d_prog = 1'b0; d_addr = 8'h00; d_data = 8'h00;
        for (int k = 0; k < 256; k++) ref_mem[k] = 8'(k) ^ 8'h5A;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_h_ready", {31'd0, h_ready}, 32'd0);
        check("rst_d_ready", {31'd0, d_ready}, 32'd0);
        check("rst_strobes", {30'd0, snoopm, snoopp}, 32'd0);
        check("rst_snoopa", {24'd0, snoopa}, 32'd0);
        check("rst_snoopd", {24'd0, snoopd}, 32'd0);
        check("rst_rsp", {22'd0, rsp_valid, rsp_src, rsp_data}, 32'd0);
        check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
`ifdef DISCUS_SNOOP_PROG_LOCK_EN
        check("rst_lock_err", {31'd0, prog_lock_err}, 32'd0);
`endif
        reset = 1'b1;

        // Both requesters stream writes: host first, bursts of BM, alternating.
        hi = 0; di = 0;
        acc_log.delete();
        for (int c = 0; c < 17; c++) begin
            step(1'b1, 1'b1, 1'b0, 8'(8'h20 + hi), 8'(8'h80 + hi),
                 1'b1, 1'b1, 1'b0, 8'(8'h40 + di), 8'(8'hC0 + di), ha, da);
            if (ha) hi++;
            if (da) di++;
        end
        check("burst_count", acc_log.size(), 32'd16);
        for (int c = 0; c < 16 && c < acc_log.size(); c++)
            check("burst_order", {31'd0, acc_log[c]}, ((c / BM) % 2));
        idle(3);

        // Host data write then debug read-back.
        host_txn(1'b1, 1'b0, 8'h10, 8'hA5);
        dbg_txn(1'b0, 1'b0, 8'h10, 8'h00);
        idle(5);

        // Eight back-to-back host reads.
        i = 0;
        for (int k = 0; k < 20 && i < 8; k++) begin
            step(1'b1, 1'b0, 1'b0, 8'(i), 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, ha, da);
            if (ha) i++;
        end
        check("stream_reads", i, 32'd8);
        idle(5);

        // Program-memory read answers zero.
        host_txn(1'b0, 1'b1, 8'h03, 8'h00);
        idle(5);

        // Program load under h_hold, released with the last accept.
        h_hold = 1'b1;
        idle(1);
        check("hold_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        i = 0;
        for (int k = 0; k < 40 && i < 16; k++) begin
            if (i == 15 && h_ready) h_hold = 1'b0;
            step(1'b1, 1'b1, 1'b1, 8'(i), 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, ha, da);
            if (ha) i++;
        end
        check("prog_count", i, 32'd16);
        check("prog_last_strobe", {31'd0, snoopp}, 32'd1);
        check("cpu_reset_during_last", {31'd0, cpu_reset}, 32'd1);
        idle(1);
        check("cpu_reset_after_last", {31'd0, cpu_reset}, 32'd1);
        idle(1);
        check("cpu_reset_released", {31'd0, cpu_reset}, 32'd0);
        check("pmem0", {24'd0, pmem[0]}, 32'hC0);
        check("pmem15", {24'd0, pmem[15]}, 32'hCF);
        idle(2);

        // Reset one cycle after a read accept: the read is dropped.
        host_txn(1'b0, 1'b0, 8'h21, 8'h00);
        reset = 1'b0;
        rsp_q.delete();
        idle(1);
        check("mid_rst_ready", {30'd0, h_ready, d_ready}, 32'd0);
        check("mid_rst_strobes", {30'd0, snoopm, snoopp}, 32'd0);
        check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        idle(1);
        reset = 1'b1;
        idle(6);

`ifdef DISCUS_SNOOP_PROG_LOCK_EN
        check("lock_cpu_running", {31'd0, cpu_reset}, 32'd0);
        lock_on = 1'b1;
        dbg_txn(1'b1, 1'b1, 8'h05, 8'h77);
        idle(3);
        check("lock_err_set", {31'd0, prog_lock_err}, 32'd1);
        lock_on = 1'b0;
        h_hold = 1'b1;
        idle(1);
        dbg_txn(1'b1, 1'b1, 8'h06, 8'h78);
        idle(3);
        check("lock_held_write", {24'd0, pmem[6]}, 32'h78);
        check("lock_err_sticky", {31'd0, prog_lock_err}, 32'd1);
        h_hold = 1'b0;
        idle(3);
`endif

        idle(5);
        check("rsp_queue_empty", rsp_q.size(), 32'd0);
        check("snoop_queue_empty", snp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
